// File: rtl/wb_write_arbiter.sv
// Register file write-port arbiter: single-cycle pipe writebacks win the slot,
// long-latency results are queued in a small FIFO and drained into idle slots.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pipeWrite/pipeAddr/pipeData     pipeline writeback request
//   slowValid/slowAddr/slowData     slow unit result, accepted when slowReady
//   slowReady                       FIFO has room (state only)
//   issueSlow/issueAddr             decode issued a slow op to issueAddr
//   addrWrite/writeData/writeReg    register file write port
//   pendingMask                     registers still awaiting a slow result
//   fifoCount                       number of buffered slow results
//   stallPipe                       buffered results have waited too long
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipeWrite,
    input  logic [4:0]               pipeAddr,
    input  logic [31:0]              pipeData,
    input  logic                     slowValid,
    input  logic [4:0]               slowAddr,
    input  logic [31:0]              slowData,
    output logic                     slowReady,
    input  logic                     issueSlow,
    input  logic [4:0]               issueAddr,
    output logic [4:0]               addrWrite,
    output logic [31:0]              writeData,
    output logic                     writeReg,
    output logic [31:0]              pendingMask,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic                     stallPipe
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve;
    logic [31:0]   mask;
    logic [31:0]   mask_next;

    logic          pipe_live;
    logic          fifo_any;
    logic          pop;
    logic          push;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // A write to r0 is a no-op, so that slot is free for the FIFO.
    assign pipe_live = pipeWrite && (pipeAddr != 5'd0);
    assign fifo_any  = (count != '0);

    assign slowReady = !rst && (count != (AW+1)'(DEPTH));
    assign pop       = !rst && !pipe_live && fifo_any;
    // r0 results complete the handshake but are dropped.
    assign push      = slowValid && slowReady && (slowAddr != 5'd0);

    always_comb begin
        writeReg  = 1'b0;
        addrWrite = 5'd0;
        writeData = 32'd0;
        if (!rst) begin
            if (pipe_live) begin
                writeReg  = 1'b1;
                addrWrite = pipeAddr;
                writeData = pipeData;
            end else if (fifo_any) begin
                writeReg  = 1'b1;
                addrWrite = head_addr;
                writeData = head_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= slowAddr;
            data_mem[wr_ptr] <= slowData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue sets after the pop clears, so a re-issue in the pop cycle sticks.
    always_comb begin
        mask_next = mask;
        if (pop) mask_next[head_addr] = 1'b0;
        if (issueSlow && (issueAddr != 5'd0)) mask_next[issueAddr] = 1'b1;
        mask_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) mask <= '0;
        else     mask <= mask_next;
    end

    always_ff @(posedge clk) begin
        if (rst || pop || !fifo_any) begin
            starve <= '0;
        end else if (starve != SW'(STARVE_LIMIT)) begin
            starve <= starve + SW'(1);
        end
    end

    assign stallPipe   = (starve == SW'(STARVE_LIMIT));
    assign pendingMask = mask;
    assign fifoCount   = count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed table, hand sequences
// for reset/full/starvation, and random stimulus against a queue-based model.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipeWrite;
    logic [4:0]  pipeAddr;
    logic [31:0] pipeData;
    logic        slowValid;
    logic [4:0]  slowAddr;
    logic [31:0] slowData;
    logic        slowReady;
    logic        issueSlow;
    logic [4:0]  issueAddr;
    logic [4:0]  addrWrite;
    logic [31:0] writeData;
    logic        writeReg;
    logic [31:0] pendingMask;
    logic [2:0]  fifoCount;
    logic        stallPipe;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .pipeWrite(pipeWrite), .pipeAddr(pipeAddr), .pipeData(pipeData),
        .slowValid(slowValid), .slowAddr(slowAddr), .slowData(slowData),
        .slowReady(slowReady),
        .issueSlow(issueSlow), .issueAddr(issueAddr),
        .addrWrite(addrWrite), .writeData(writeData), .writeReg(writeReg),
        .pendingMask(pendingMask), .fifoCount(fifoCount),
        .stallPipe(stallPipe)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO as queues, scoreboard as a bit vector.
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    logic [31:0] mmask = '0;
    int          mstarve = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_compare();
        logic        live;
        logic        ewr;
        logic [4:0]  ea;
        logic [31:0] ed;
        live = pipeWrite && (pipeAddr != 0);
        ewr = 0; ea = 0; ed = 0;
        if (!rst) begin
            if (live) begin
                ewr = 1; ea = pipeAddr; ed = pipeData;
            end else if (qa.size() > 0) begin
                ewr = 1; ea = qa[0]; ed = qd[0];
            end
        end
        chk("m_writeReg", 32'(writeReg), 32'(ewr));
        chk("m_addrWrite", 32'(addrWrite), 32'(ea));
        chk("m_writeData", writeData, ed);
        chk("m_slowReady", 32'(slowReady),
            32'(!rst && qa.size() != DEPTH));
        chk("m_fifoCount", 32'(fifoCount), 32'(qa.size()));
        chk("m_pendingMask", pendingMask, mmask);
        chk("m_stallPipe", 32'(stallPipe), 32'(mstarve == LIM));
    endtask

    task automatic model_update();
        logic       live;
        logic       pop;
        logic       acc;
        logic [4:0] pa;
        logic [31:0] pd;
        if (rst) begin
            qa.delete(); qd.delete(); mmask = '0; mstarve = 0;
            return;
        end
        live = pipeWrite && (pipeAddr != 0);
        if (live && mmask[pipeAddr])
            $error("usage error: pipe write to pending r%0d", pipeAddr);
        pop = !live && qa.size() > 0;
        acc = slowValid && qa.size() != DEPTH;
        if (pop || qa.size() == 0) mstarve = 0;
        else if (mstarve < LIM) mstarve++;
        if (pop) begin
            pa = qa.pop_front();
            pd = qd.pop_front();
            mmask[pa] = 1'b0;
        end
        if (acc && slowAddr != 0) begin
            qa.push_back(slowAddr);
            qd.push_back(slowData);
        end
        if (issueSlow && issueAddr != 0) mmask[issueAddr] = 1'b1;
    endtask

    task automatic set_in(logic pw, logic [4:0] pa, logic [31:0] pd,
                          logic sv, logic [4:0] sa, logic [31:0] sd,
                          logic is, logic [4:0] ia);
        pipeWrite = pw; pipeAddr = pa; pipeData = pd;
        slowValid = sv; slowAddr = sa; slowData = sd;
        issueSlow = is; issueAddr = ia;
        #1;
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        sv;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic        is;
        logic [4:0]  ia;
        logic        ewr;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [2:0]  ecnt;
        logic        erdy;
        logic [31:0] emask;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [4:0] order[5];
        tbl[0]  = '{0,0,0,         1,5,32'hAAAA0005,1,12, 0,0,0,            0,1,32'h0};
        tbl[1]  = '{1,7,32'h77,    0,0,0,           0,0,  1,7,32'h77,       1,1,32'h1000};
        tbl[2]  = '{1,7,32'h77,    0,0,0,           0,0,  1,7,32'h77,       1,1,32'h1000};
        tbl[3]  = '{0,0,0,         1,12,32'hC0C0,   0,0,  1,5,32'hAAAA0005, 1,1,32'h1000};
        tbl[4]  = '{0,0,0,         0,0,0,           1,12, 1,12,32'hC0C0,    1,1,32'h1000};
        tbl[5]  = '{0,0,0,         0,0,0,           0,0,  0,0,0,            0,1,32'h1000};
        tbl[6]  = '{0,0,0,         0,0,0,           1,0,  0,0,0,            0,1,32'h1000};
        tbl[7]  = '{0,0,0,         1,0,32'hDEAD,    0,0,  0,0,0,            0,1,32'h1000};
        tbl[8]  = '{1,0,32'h55,    1,3,32'h33,      0,0,  0,0,0,            0,1,32'h1000};
        tbl[9]  = '{1,0,32'h55,    0,0,0,           0,0,  1,3,32'h33,       1,1,32'h1000};
        tbl[10] = '{0,0,0,         0,0,0,           0,0,  0,0,0,            0,1,32'h1000};
        tbl[11] = '{0,0,0,         1,12,32'h1212,   0,0,  0,0,0,            0,1,32'h1000};
        tbl[12] = '{0,0,0,         0,0,0,           0,0,  1,12,32'h1212,    1,1,32'h1000};
        tbl[13] = '{0,0,0,         0,0,0,           0,0,  0,0,0,            0,1,32'h0};

        rst = 1'b1;
        pipeWrite = 0; pipeAddr = 0; pipeData = 0;
        slowValid = 0; slowAddr = 0; slowData = 0;
        issueSlow = 0; issueAddr = 0;
        tick();
        tick();
        rst = 1'b0;
        idle();
        chk("reset_count", 32'(fifoCount), 0);
        chk("reset_mask", pendingMask, 0);
        chk("reset_ready", 32'(slowReady), 1);
        chk("reset_stall", 32'(stallPipe), 0);
        tick();

        // Reset in the middle of buffering three results.
        for (int i = 1; i <= 3; i++) begin
            set_in(1, 7, 32'h77, 1, 5'(i), 32'h100 + i, 1, 20);
            tick();
        end
        chk("pre_rst_count", 32'(fifoCount), 3);
        rst = 1'b1;
        set_in(1, 7, 32'h77, 1, 4, 32'h104, 0, 0);
        chk("rst_writeReg", 32'(writeReg), 0);
        chk("rst_ready", 32'(slowReady), 0);
        tick();
        rst = 1'b0;
        idle();
        chk("post_rst_count", 32'(fifoCount), 0);
        chk("post_rst_mask", pendingMask, 0);
        chk("post_rst_ready", 32'(slowReady), 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_rst_nowrite", 32'(writeReg), 0);
            tick();
        end

        // Fill to full behind a busy pipe, then drain with wrap.
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 7, 32'h77, 1, 5'(i), 32'h100 + i, 0, 0);
            chk("fill_ready", 32'(slowReady), 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 7, 32'h77, 1, 9, 32'h109, 0, 0);
            chk("full_ready", 32'(slowReady), 0);
            chk("full_count", 32'(fifoCount), 4);
            tick();
        end
        order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, (k <= 1), 9, 32'h109, 0, 0);
            chk("drain_wr", 32'(writeReg), 1);
            chk("drain_addr", 32'(addrWrite), 32'(order[k]));
            chk("drain_data", writeData, 32'h100 + order[k]);
            if (k == 1) chk("pushpop_count", 32'(fifoCount), 3);
            tick();
        end
        idle();
        chk("drain_empty", 32'(fifoCount), 0);
        tick();

        // Starvation: one buffered entry behind a continuously busy pipe.
        set_in(0, 0, 0, 1, 6, 32'h606, 0, 0);
        tick();
        for (int k = 0; k <= LIM; k++) begin
            set_in(1, 7, 32'h77, 0, 0, 0, 0, 0);
            chk("starve_stall", 32'(stallPipe), 32'(k == LIM));
            tick();
        end
        idle();
        chk("starve_pop_stall", 32'(stallPipe), 1);
        chk("starve_pop_addr", 32'(addrWrite), 6);
        tick();
        idle();
        chk("starve_clear", 32'(stallPipe), 0);
        tick();

        // Directed table.
        foreach (tbl[i]) begin
            set_in(tbl[i].pw, tbl[i].pa, tbl[i].pd,
                   tbl[i].sv, tbl[i].sa, tbl[i].sd,
                   tbl[i].is, tbl[i].ia);
            chk($sformatf("t%0d_wr", i), 32'(writeReg), 32'(tbl[i].ewr));
            chk($sformatf("t%0d_addr", i), 32'(addrWrite), 32'(tbl[i].ea));
            chk($sformatf("t%0d_data", i), writeData, tbl[i].ed);
            chk($sformatf("t%0d_cnt", i), 32'(fifoCount), 32'(tbl[i].ecnt));
            chk($sformatf("t%0d_rdy", i), 32'(slowReady), 32'(tbl[i].erdy));
            chk($sformatf("t%0d_mask", i), pendingMask, tbl[i].emask);
            tick();
        end

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic       pw;
            logic [4:0] pa;
            rst = ($urandom_range(0, 99) == 0);
            pw = ($urandom_range(0, 99) < 55);
            pa = 5'($urandom_range(0, 31));
            if (mmask[pa]) pa = 5'd0;
            set_in(pw, pa, $urandom,
                   ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)),
                   $urandom,
                   ($urandom_range(0, 99) < 20), 5'($urandom_range(0, 31)));
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Sole driver of the register file write port (addrWrite/writeData/writeReg). Merges single-cycle pipeline writebacks with results from long-latency units (mul/div, loads) via a valid/ready handshake and a small FIFO. Keeps a 32-bit scoreboard of registers awaiting a slow result so decode can stall. Raises a starvation request when buffered results wait too long for a free write slot.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive non-popping cycles with FIFO non-empty before stallPipe asserts (>=1)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
pipeWrite  input  1  pipeline writeback request this cycle
pipeAddr  input  5  pipeline destination register
pipeData  input  32  pipeline result
slowValid  input  1  slow unit result valid
slowAddr  input  5  slow unit destination register
slowData  input  32  slow unit result
slowReady  output  1  FIFO can accept a slow result
issueSlow  input  1  decode issued a slow op this cycle
issueAddr  input  5  destination of that slow op
addrWrite  output  5  to register file write address
writeData  output  32  to register file write data
writeReg  output  1  to register file write enable
pendingMask  output  32  bit r = register r awaits a slow result
fifoCount  output  $clog2(DEPTH)+1  buffered entries
stallPipe  output  1  request one pipeline bubble so the FIFO can drain

Behaviour:
- Reset (rst high at posedge): FIFO pointers and count = 0, pendingMask = 0, starve counter = 0, stallPipe = 0. Buffered entries are discarded. While rst is high: writeReg = 0, slowReady = 0, no push, no pop.
- Write slot is combinational, with the register file writing at the following posedge:
  - Pipe slot is live when pipeWrite=1 and pipeAddr!=0. It always wins: writeReg=1, addrWrite=pipeAddr, writeData=pipeData, no pop.
  - Otherwise, if fifoCount>0: FIFO head drives addrWrite/writeData, writeReg=1, and the head pops at the posedge.
  - Otherwise: writeReg=0, addrWrite=0, writeData=0.
- pipeWrite with pipeAddr=0 is treated as an idle slot, so the FIFO may use it.
- slowReady = (fifoCount != DEPTH). It depends only on state and is never combinational on slowValid or the pop.
- Push happens on slowValid && slowReady at the posedge. With slowAddr=0 the handshake completes but nothing is pushed.
- Push and pop in the same cycle: count unchanged, pointers both advance. Pointers wrap modulo DEPTH. No push when full, even if popping that cycle.
- Push into an empty FIFO is not visible on the write port until the next cycle (no bypass). Minimum slow-result latency is 1 cycle from accept to writeReg.
- pendingMask:
  - Set bit issueAddr at the posedge when issueSlow=1 and issueAddr!=0.
  - Clear bit addrWrite at the posedge when a FIFO pop occurs.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is constant 0.
  - Pipe writes never clear bits.
  - Popping a register whose bit is already 0 leaves the mask unchanged.
- Ordering: entries pop in push order. The block never reorders against the pipe slot. Decode must stall on pendingMask, so a live pipe write to a pending register is a usage error; the bench flags it with an assertion and the block takes no action.
- Starvation:
  - The counter increments each cycle with fifoCount>0 and no pop, saturating at STARVE_LIMIT.
  - It resets to 0 on any pop or when the FIFO is empty.
  - stallPipe = (counter == STARVE_LIMIT), combinational from the counter.
  - The pipe keeps priority while stallPipe=1. The pipeline must present an idle slot.

Test Plan:
- Reset mid-operation: push 3 entries, assert rst for 1 cycle -> fifoCount=0, pendingMask=0, writeReg=0, slowReady=0 during reset, 1 after; none of the 3 entries is ever written.
- Pipe priority: FIFO holds {r5, 0xAAAA0005}; pipeWrite=1, pipeAddr=7, pipeData=0x77 for 2 cycles, then idle -> writes r7 (twice), then r5=0xAAAA0005, fifoCount 1->0.
- Full / wrap: with pipe busy, push DEPTH entries r1..r4 -> slowReady=0 after the 4th. Push r9 with slowValid held -> not accepted until after a pop. Idle the pipe -> writes r1,r2,r3,r4,r9 in order, pointers wrap with no loss.
- Simultaneous push/pop: count=2, pipe idle, slowValid=1 -> count stays 2, head written, new entry appended at tail.
- Scoreboard: issueSlow r12 -> pendingMask=0x00001000. Slow result r12 accepted, popped next idle cycle -> bit 12 clears at that posedge. Issue r12 again in the pop cycle -> bit stays set. issueAddr=0 -> mask unchanged.
- Starvation / addr 0: with STARVE_LIMIT=8, FIFO non-empty and pipe busy 8 cycles -> stallPipe=1 on cycle 8. Idle cycle -> pop, stallPipe=0 next cycle. pipeAddr=0 with pipeWrite=1 counts as idle (pop occurs). slowAddr=0 accepted -> fifoCount unchanged.
